gpio_bank: RTL

//  Parametrised GPIO bank; successor to the 8-bit gpio block. Per-pin enable/direction,

---
 rtl/gpio_bank.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gpio_bank.sv
// gpio_bank: parametrised GPIO bank between the core register bus and the pads.
//
// Each pin has an enable and a direction bit. The pad signals are split into
// pad_in, pad_out and pad_oe, so the block never drives a bidirectional net.
// Every input passes through a synchroniser. Rising and falling edges on enabled
// input pins can set write-1-to-clear pending bits, and irq is the OR of those bits.
//
// Ports
//   clk      in   1      system clock, all logic on posedge
//   rst      in   1      synchronous reset, active-high
//   wr_en    in   1      register write strobe, one cycle per write
//   rd_en    in   1      register read strobe
//   addr     in   3      register index (all 8 decoded)
//   wdata    in   WIDTH  write data
//   rdata    out  WIDTH  read data, registered, holds between reads
//   pad_in   in   WIDTH  raw asynchronous pad inputs
//   pad_out  out  WIDTH  pad output values (OUT & pad_oe)
//   pad_oe   out  WIDTH  pad output enables, 1 = drive (EN & ~DIR)
//   irq      out  1      OR of all pending bits, registered
//
// Register map
//   0 EN  rw   1 DIR rw (1 = input)   2 OUT rw   3 IN ro
//   4 RISE rw  5 FALL rw   6 PEND W1C   7 TGL wo (OUT ^= wdata, reads 0)

module gpio_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_EN   = 3'd0,
    REG_DIR  = 3'd1,
    REG_OUT  = 3'd2,
    REG_IN   = 3'd3,
    REG_RISE = 3'd4,
    REG_FALL = 3'd5,
    REG_PEND = 3'd6,
    REG_TGL  = 3'd7
  } reg_addr_e;

  logic [WIDTH-1:0] en_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] pend_q;

  // Synchroniser chain; the last stage is the synced pad value.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_val;

  logic [WIDTH-1:0] in_mask;
  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] rise_ev;
  logic [WIDTH-1:0] fall_ev;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] pend_next;
  logic [WIDTH-1:0] rd_mux;

  assign sync_val = sync_q[SYNC_STAGES-1];

  // Pad drive comes straight from the registers, so a write shows on the pads
  // in the cycle after its write edge.
  assign pad_oe  = en_q & ~dir_q;
  assign pad_out = out_q & pad_oe;

  // Input pins report the synced pad; output pins report what they drive.
  assign in_mask = en_q & dir_q;
  assign in_val  = (sync_val & in_mask) | (out_q & pad_oe);

  assign rise_ev = sync_val & ~prev_q & rise_q & in_mask;
  assign fall_ev = ~sync_val & prev_q & fall_q & in_mask;

  // A new edge is ORed in after the clear, so an edge landing on the same
  // cycle as a W1C of that bit leaves it set.
  assign w1c       = (wr_en && addr == REG_PEND) ? wdata : '0;
  assign pend_next = (pend_q & ~w1c) | rise_ev | fall_ev;

  // NOTE: every combinational output gets a default before the case so that no
  // path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_EN:   rd_mux = en_q;
      REG_DIR:  rd_mux = dir_q;
      REG_OUT:  rd_mux = out_q;
      REG_IN:   rd_mux = in_val;
      REG_RISE: rd_mux = rise_q;
      REG_FALL: rd_mux = fall_q;
      REG_PEND: rd_mux = pend_q;
      REG_TGL:  rd_mux = '0;
      default:  rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values; that is what makes a read alongside a write to the
  // same address return the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= '0;
      dir_q  <= '0;
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      pend_q <= '0;
      prev_q <= '0;
      rdata  <= '0;
      irq    <= 1'b0;
      // The synchroniser is cleared too, so sync and prev agree after reset
      // and no edge is seen from the zeroed history.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_val;

      pend_q <= pend_next;
      irq    <= |pend_next;

      if (wr_en) begin
        case (addr)
          REG_EN:   en_q   <= wdata;
          REG_DIR:  dir_q  <= wdata;
          REG_OUT:  out_q  <= wdata;
          REG_RISE: rise_q <= wdata;
          REG_FALL: fall_q <= wdata;
          REG_TGL:  out_q  <= out_q ^ wdata;
          default:  ;  // IN is read-only; PEND is handled through w1c
        endcase
      end

      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

endmodule
